// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the bit-serial ALU datapath blocks.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int WIDTH_DEFAULT = 4;

    // Counter width for WIDTH bit-steps; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor: d = x - y - z, with borrow-out bo.
module sub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ z;
    assign bo = (~x & (y | z)) | (y & z);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell walked LSB-first across WIDTH bits.
module serial_sub_ctrl
    import alu_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin_in,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             bout_out,
    output logic             zero_out,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d, r_sh_q, r_sh_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d, zero_q, zero_d, res_valid_q;
    logic               cell_d, cell_bo;

    sub_bit_cell u_cell (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .z  (borrow_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_sh_d   = a_in;
                    b_sh_d   = b_in;
                    borrow_d = bin_in;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // abort wins over the final step, so a cancelled op never publishes
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    r_sh_d   = {cell_d, r_sh_q[WIDTH-1:1]};
                    a_sh_d   = a_sh_q >> 1;
                    b_sh_d   = b_sh_q >> 1;
                    borrow_d = cell_bo;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        diff_d  = r_sh_d;
                        bout_d  = cell_bo;
                        zero_d  = (r_sh_d == '0);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (abort || res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            r_sh_q      <= '0;
            borrow_q    <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            r_sh_q      <= r_sh_d;
            borrow_q    <= borrow_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            zero_q      <= zero_d;
            res_valid_q <= (state_d == DONE);
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign res_valid   = res_valid_q;
    assign diff_out    = diff_q;
    assign bout_out    = bout_q;
    assign zero_out    = zero_q;

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction controller that time-shares a single one-bit full-subtractor cell across a WIDTH-bit operand pair, LSB first.
- Sits between the ALU operand registers and the result bus.
- Accepts an operation through a valid/ready handshake, sequences WIDTH bit-steps while carrying the borrow in a flip-flop, then presents the result through a second valid/ready handshake.
- Replaces a WIDTH-cell ripple chain with one cell plus control, trading latency for area.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-step counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  operation request.
- start_ready  output  1  controller can accept a request; high only in IDLE.
- a_in  input  WIDTH  minuend; sampled on the accept edge.
- b_in  input  WIDTH  subtrahend; sampled on the accept edge.
- bin_in  input  1  initial borrow-in; sampled on the accept edge.
- abort  input  1  synchronous cancel of the current operation.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- diff_out  output  WIDTH  a_in - b_in - bin_in, modulo 2^WIDTH.
- bout_out  output  1  final borrow-out from the MSB step.
- zero_out  output  1  diff_out == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset: state=IDLE; start_ready=1; res_valid=0; busy=0; diff_out, bout_out and zero_out=0; borrow flop=0; step counter=0; operand shift registers cleared. Reset is asynchronous on assertion; release is taken synchronously to clk.
- States: IDLE, RUN, DONE.
- IDLE:
  - Accept when start_valid && start_ready at a rising edge.
  - On that edge, load a_sh=a_in, b_sh=b_in, borrow=bin_in, cnt=0; move to RUN.
  - start_valid while busy is ignored; the requester must hold it.
- RUN, one bit per cycle:
  - Cell inputs: x=a_sh[0], y=b_sh[0], z=borrow.
  - Cell equations: d = x^y^z; bo = (~x & (y|z)) | (y & z).
  - Each edge: shift d into the MSB of the result shift register; shift a_sh and b_sh right by one; borrow <= bo; cnt++.
  - When cnt==WIDTH-1, the same edge moves to DONE. That edge loads diff_out from the completed register, bout_out from bo, and zero_out.
- Latency: res_valid rises exactly WIDTH cycles after the accept edge (WIDTH=4: accept at edge 0, res_valid high after edge 4).
- DONE:
  - res_valid=1.
  - diff_out, bout_out and zero_out hold stable until res_valid && res_ready; the next state is then IDLE.
  - start_ready=0 throughout DONE, so no same-cycle back-to-back. The next accept is possible at the earliest one cycle after the result handshake.
- abort:
  - In RUN or DONE: next state IDLE, res_valid=0, outputs keep their last values, no result handshake.
  - In IDLE: no effect. abort has priority over res_ready and over RUN completion in the same cycle.
- Outputs are registered; the only combinational outputs are start_ready and busy, decoded from state.
- Reset mid-RUN or mid-DONE: immediate return to the reset values above; the partial result is discarded.
- Boundaries:
  - a==b with bin=0 gives diff 0, zero 1, bout 0.
  - Wrap-around is modulo 2^WIDTH, with bout_out=1 flagging underflow.
  - The counter never exceeds WIDTH-1.

Decomposition:
- Shared package alu_pkg holds:
  - the state enum (IDLE/RUN/DONE, 2-bit encoding 00/01/10);
  - localparam WIDTH_DEFAULT=4;
  - a function computing CNT_W.
- One natural sub-module: sub_bit_cell, the purely combinational x/y/z -> d/bo cell, instantiated once. The controller contains the FSM, counter, shift registers and borrow flop.

Test Plan:
- Basic subtract: WIDTH=4, a=9, b=5, bin=0 -> res_valid exactly 4 cycles after accept; diff=4, bout=0, zero=0.
- Underflow: a=3, b=5, bin=0 -> diff=4'hE, bout=1. Also a=0, b=0, bin=1 -> diff=4'hF, bout=1.
- Equal operands: a=7, b=7, bin=0 -> diff=0, zero=1, bout=0.
- Backpressure: hold res_ready=0 for 3 cycles in DONE -> res_valid, diff and bout stable; start_ready=0; start_valid ignored. The next accept occurs only the cycle after res_ready=1.
- Abort and reset:
  - Assert abort at RUN step 2 -> IDLE next cycle, res_valid never rises; a new op a=12, b=1 then yields diff=11.
  - Repeat with rst_n low mid-RUN, asynchronous -> all outputs at reset values immediately.
- Exhaustive random: all 512 (a, b, bin) combinations for WIDTH=4, back-to-back with res_ready random -> every result matches a-b-bin mod 16 and the borrow, in order.
